// File: rtl/bias_stream_ctrl_pkg.sv
// Shared definitions for the bias coefficient streamer: controller state
// encoding and the ROM address width helper.
package bias_stream_ctrl_pkg;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE  = 2'd0;
  localparam state_t S_RUN   = 2'd1;
  localparam state_t S_DRAIN = 2'd2;
  localparam state_t S_DONE  = 2'd3;

  // ceil(log2(n)) with a floor of one bit so tiny ROMs still get a port
  function automatic int unsigned addr_width(input int unsigned n);
    if (n <= 2) return 1;
    return $clog2(n);
  endfunction

endpackage

// File: rtl/bias_skid_buf.sv
// Two-entry FIFO holding ROM words between capture and the output FIFO write.
// Push and pop in the same cycle leave the occupancy unchanged.
module bias_skid_buf #(
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] head,
  output logic [1:0]            count
);

  logic [DATA_WIDTH-1:0] mem [2];
  logic                  rd_ptr;
  logic                  wr_ptr;
  logic                  do_pop;

  assign do_pop = pop && (count != 2'd0);
  assign head   = mem[rd_ptr];

  // storage, pointers and occupancy update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      case ({push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/bias_stream_ctrl.sv
// Streams MEM_SIZE bias coefficients from a ROM into an output FIFO,
// REPEAT passes per ap_start. Optional feature macro:
// BIAS_STREAM_CTRL_STALL_CNT_EN adds a 32-bit saturating stall_count port.
module bias_stream_ctrl
  import bias_stream_ctrl_pkg::*;
#(
  parameter int unsigned MEM_SIZE   = 16,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned REPEAT     = 1
) (
  input  logic                                  ap_clk,
  input  logic                                  ap_rst_n,
  input  logic                                  ap_start,
  output logic                                  ap_idle,
  output logic                                  ap_done,
  output logic [addr_width(MEM_SIZE)-1:0]       rom_address,
  output logic                                  rom_ce,
  input  logic [DATA_WIDTH-1:0]                 rom_q,
  output logic [DATA_WIDTH-1:0]                 output_V_din,
  input  logic                                  output_V_full_n,
  output logic                                  output_V_write
`ifdef BIAS_STREAM_CTRL_STALL_CNT_EN
  ,
  output logic [31:0]                           stall_count
`endif
);

  localparam int unsigned AW    = addr_width(MEM_SIZE);
  localparam int unsigned TOTAL = MEM_SIZE * REPEAT;

  state_t          state;
  state_t          state_nx;
  logic [AW-1:0]   addr;
  logic [31:0]     rd_cnt;
  logic            inflight;
  logic [1:0]      occ;
  logic [1:0]      occ_eff;
  logic            pop;
  logic            rd_issue;
  logic            last_read;
  logic            start_acc;

  assign start_acc = (state == S_IDLE) && ap_start;
  assign pop       = (occ != 2'd0) && output_V_full_n;
  // Occupancy after this cycle's pop: lets a read issue in the same cycle a
  // word leaves, which is what sustains one write per cycle.
  assign occ_eff   = occ - {1'b0, pop};
  assign rd_issue  = (state == S_RUN) &&
                     ((occ_eff == 2'd0) || ((occ_eff == 2'd1) && !inflight));
  assign last_read = rd_issue && (rd_cnt == 32'(TOTAL - 1));

  assign ap_idle        = (state == S_IDLE);
  assign ap_done        = (state == S_DONE);
  assign rom_ce         = rd_issue;
  assign rom_address    = addr;
  assign output_V_write = pop;

  // next-state selection
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (ap_start) state_nx = S_RUN;
      S_RUN:   if (last_read) state_nx = S_DRAIN;
      S_DRAIN: if ((occ_eff == 2'd0) && !inflight) state_nx = S_DONE;
      default: state_nx = S_IDLE;
    endcase
  end

  // state, read tracking and address generation
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state    <= S_IDLE;
      addr     <= '0;
      rd_cnt   <= '0;
      inflight <= 1'b0;
    end else begin
      state    <= state_nx;
      inflight <= rd_issue;
      if (start_acc) begin
        addr   <= '0;
        rd_cnt <= '0;
      end else if (rd_issue) begin
        addr   <= (addr == AW'(MEM_SIZE - 1)) ? '0 : addr + AW'(1);
        rd_cnt <= rd_cnt + 32'd1;
      end
    end
  end

  bias_skid_buf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_buf (
    .clk   (ap_clk),
    .rst_n (ap_rst_n),
    .push  (inflight),
    .pop   (pop),
    .din   (rom_q),
    .head  (output_V_din),
    .count (occ)
  );

`ifdef BIAS_STREAM_CTRL_STALL_CNT_EN
  logic [31:0] stall_cnt;

  assign stall_count = stall_cnt;

  // cycles with data waiting on a full output FIFO, saturating
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      stall_cnt <= '0;
    end else if (start_acc) begin
      stall_cnt <= '0;
    end else if ((occ != 2'd0) && !output_V_full_n && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_bias_stream_ctrl.sv
// Self-checking bench for bias_stream_ctrl (MEM_SIZE=4, REPEAT=2).
// Expected stream: word i of a run is rom[i mod 4], 8 words per run.
module tb_bias_stream_ctrl;

  localparam int unsigned MEM = 4;
  localparam int unsigned REP = 2;
  localparam int unsigned DW  = 16;
  localparam int unsigned AW  = 2;
  localparam int unsigned N   = MEM * REP;

  logic          ap_clk = 1'b0;
  logic          ap_rst_n = 1'b0;
  logic          ap_start = 1'b0;
  logic          ap_idle;
  logic          ap_done;
  logic [AW-1:0] rom_address;
  logic          rom_ce;
  logic [DW-1:0] rom_q = '0;
  logic [DW-1:0] output_V_din;
  logic          output_V_full_n = 1'b1;
  logic          output_V_write;
`ifdef BIAS_STREAM_CTRL_STALL_CNT_EN
  logic [31:0]   stall_count;
`endif

  bias_stream_ctrl #(
    .MEM_SIZE(MEM),
    .DATA_WIDTH(DW),
    .REPEAT(REP)
  ) dut (
    .ap_clk          (ap_clk),
    .ap_rst_n        (ap_rst_n),
    .ap_start        (ap_start),
    .ap_idle         (ap_idle),
    .ap_done         (ap_done),
    .rom_address     (rom_address),
    .rom_ce          (rom_ce),
    .rom_q           (rom_q),
    .output_V_din    (output_V_din),
    .output_V_full_n (output_V_full_n),
    .output_V_write  (output_V_write)
`ifdef BIAS_STREAM_CTRL_STALL_CNT_EN
    ,
    .stall_count     (stall_count)
`endif
  );

  always #5 ap_clk = ~ap_clk;

  logic [DW-1:0] rom [MEM];

  // synchronous ROM: data valid the cycle after rom_ce
  always @(posedge ap_clk) if (rom_ce) rom_q <= rom[rom_address];

  int unsigned cyc = 0;
  always @(posedge ap_clk) cyc <= cyc + 1;

  logic [DW-1:0] wr_val [$];
  int unsigned   wr_cyc [$];
  int unsigned   rd_cyc [$];
  int unsigned   done_cyc [$];
  int unsigned   bad_wr = 0;

  // observe DUT away from the rising edge
  always @(negedge ap_clk) begin
    if (output_V_write) begin
      wr_val.push_back(output_V_din);
      wr_cyc.push_back(cyc);
      if (!output_V_full_n) bad_wr++;
    end
    if (rom_ce) rd_cyc.push_back(cyc);
    if (ap_done) done_cyc.push_back(cyc);
  end

  // full_n pattern generator; s is the cycle tag of the start edge
  int          mode = 0;
  int unsigned s = 0;
  always @(posedge ap_clk) begin
    #2;
    case (mode)
      1:       output_V_full_n = !((cyc >= s + 1) && (cyc <= s + 8));
      2:       output_V_full_n = ((cyc % 2) == 0);
      3:       output_V_full_n = 1'($urandom_range(0, 1));
      default: output_V_full_n = 1'b1;
    endcase
  end

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  function automatic logic [DW-1:0] ref_val(input int unsigned i);
    return rom[i % MEM];
  endfunction

  task automatic clear_q();
    wr_val.delete(); wr_cyc.delete(); rd_cyc.delete(); done_cyc.delete();
    bad_wr = 0;
  endtask

  task automatic do_start(input bit hold);
    @(posedge ap_clk); #1;
    clear_q();
    ap_start = 1'b1;
    @(posedge ap_clk); #1;
    s = cyc;
    if (!hold) ap_start = 1'b0;
  endtask

  task automatic wait_done(input int unsigned n, output bit ok);
    for (int i = 0; i < 400 && done_cyc.size() < n; i++) begin
      @(negedge ap_clk); #1;
    end
    ok = (done_cyc.size() >= n);
  endtask

  task automatic load_rom_default();
    rom[0] = 16'd10; rom[1] = 16'd20; rom[2] = 16'd30; rom[3] = 16'd40;
  endtask

  task automatic test_reset();
    ap_rst_n = 1'b0;
    repeat (2) @(negedge ap_clk);
    n_cmp++;
    if ({ap_idle, ap_done, rom_ce, output_V_write} !== 4'b1000) begin
      n_bad++;
      $display("FAIL reset_ctrl: got %b expected 1000",
               {ap_idle, ap_done, rom_ce, output_V_write});
    end
    n_cmp++;
    if (rom_address !== '0 || output_V_din !== '0) begin
      n_bad++;
      $display("FAIL reset_data: addr %0d din %0d expected 0 0", rom_address, output_V_din);
    end
    @(posedge ap_clk); #1 ap_rst_n = 1'b1;
    repeat (2) @(posedge ap_clk);
  endtask

  task automatic test_stream();
    bit ok;
    mode = 0;
    do_start(1'b0);
    wait_done(1, ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL stream_done: got timeout expected ap_done"); end
    n_cmp++;
    if (wr_val.size() !== N) begin
      n_bad++; $display("FAIL stream_count: got %0d expected %0d", wr_val.size(), N);
    end
    for (int i = 0; i < wr_val.size() && i < N; i++) begin
      n_cmp++;
      if (wr_val[i] !== ref_val(i) || wr_cyc[i] !== s + 2 + i) begin
        n_bad++;
        $display("FAIL stream_word%0d: got %0d@%0d expected %0d@%0d",
                 i, wr_val[i], wr_cyc[i], ref_val(i), s + 2 + i);
      end
    end
    n_cmp++;
    if (rd_cyc.size() !== N || (rd_cyc.size() > 0 && rd_cyc[0] !== s)) begin
      n_bad++; $display("FAIL stream_reads: got %0d reads expected %0d starting at %0d",
                        rd_cyc.size(), N, s);
    end
    if (ok && wr_cyc.size() > 0) begin
      n_cmp++;
      if (done_cyc[0] !== wr_cyc[wr_cyc.size()-1] + 1) begin
        n_bad++; $display("FAIL stream_done_time: got %0d expected %0d",
                          done_cyc[0], wr_cyc[wr_cyc.size()-1] + 1);
      end
    end
    repeat (3) @(negedge ap_clk);
    n_cmp++;
    if (done_cyc.size() !== 1 || ap_idle !== 1'b1) begin
      n_bad++; $display("FAIL stream_idle: got done_pulses %0d idle %b expected 1 1",
                        done_cyc.size(), ap_idle);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int unsigned early_rd = 0;
    int unsigned early_wr = 0;
    do_start(1'b0);
    mode = 1;
    wait_done(1, ok);
    mode = 0;
    foreach (rd_cyc[i]) if (rd_cyc[i] <= s + 8) early_rd++;
    foreach (wr_cyc[i]) if (wr_cyc[i] <= s + 8) early_wr++;
    n_cmp++;
    if (!ok || early_rd > 2 || early_wr !== 0) begin
      n_bad++; $display("FAIL bp_hold: got done %0b reads %0d writes %0d expected 1 <=2 0",
                        ok, early_rd, early_wr);
    end
    n_cmp++;
    if (wr_val.size() !== N || bad_wr !== 0) begin
      n_bad++; $display("FAIL bp_count: got %0d writes (%0d while full) expected %0d (0)",
                        wr_val.size(), bad_wr, N);
    end
    for (int i = 0; i < wr_val.size() && i < N; i++) begin
      n_cmp++;
      if (wr_val[i] !== ref_val(i)) begin
        n_bad++; $display("FAIL bp_word%0d: got %0d expected %0d", i, wr_val[i], ref_val(i));
      end
    end
`ifdef BIAS_STREAM_CTRL_STALL_CNT_EN
    n_cmp++;
    if (stall_count !== 32'd7 && stall_count !== 32'd8) begin
      n_bad++; $display("FAIL bp_stall_count: got %0d expected 7 or 8", stall_count);
    end
`endif
  endtask

  task automatic test_alternating();
    bit ok;
    do_start(1'b0);
    mode = 2;
    wait_done(1, ok);
    mode = 0;
    n_cmp++;
    if (!ok || wr_val.size() !== N || bad_wr !== 0) begin
      n_bad++; $display("FAIL alt_count: got done %0b writes %0d bad %0d expected 1 %0d 0",
                        ok, wr_val.size(), bad_wr, N);
    end
    for (int i = 0; i < wr_val.size() && i < N; i++) begin
      n_cmp++;
      if (wr_val[i] !== ref_val(i)) begin
        n_bad++; $display("FAIL alt_word%0d: got %0d expected %0d", i, wr_val[i], ref_val(i));
      end
    end
  endtask

  task automatic test_random();
    bit ok;
    for (int r = 0; r < 4; r++) begin
      for (int j = 0; j < MEM; j++) rom[j] = DW'($urandom);
      do_start(1'b0);
      mode = 3;
      wait_done(1, ok);
      mode = 0;
      n_cmp++;
      if (!ok || wr_val.size() !== N || bad_wr !== 0) begin
        n_bad++; $display("FAIL rand%0d_count: got done %0b writes %0d bad %0d expected 1 %0d 0",
                          r, ok, wr_val.size(), bad_wr, N);
      end
      for (int i = 0; i < wr_val.size() && i < N; i++) begin
        n_cmp++;
        if (wr_val[i] !== ref_val(i)) begin
          n_bad++; $display("FAIL rand%0d_word%0d: got %0h expected %0h",
                            r, i, wr_val[i], ref_val(i));
        end
      end
    end
    load_rom_default();
  endtask

  task automatic test_start_held();
    bit ok;
    int unsigned first_wr = 0;
    int unsigned gap_rd = 0;
    int unsigned second_rd = 0;
    mode = 0;
    do_start(1'b1);
    wait_done(1, ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL held_done1: got timeout expected ap_done"); end
    repeat (3) @(negedge ap_clk);
    #1 ap_start = 1'b0;
    wait_done(2, ok);
    n_cmp++;
    if (!ok || wr_val.size() !== 2 * N) begin
      n_bad++; $display("FAIL held_runs: got done %0b writes %0d expected 1 %0d",
                        ok, wr_val.size(), 2 * N);
    end
    if (done_cyc.size() > 0) begin
      foreach (wr_cyc[i]) if (wr_cyc[i] < done_cyc[0]) first_wr++;
      foreach (rd_cyc[i]) begin
        if (rd_cyc[i] >= done_cyc[0] && rd_cyc[i] < done_cyc[0] + 2) gap_rd++;
        if (rd_cyc[i] >= done_cyc[0] && second_rd == 0) second_rd = rd_cyc[i];
      end
      n_cmp++;
      if (first_wr !== N || gap_rd !== 0 || second_rd !== done_cyc[0] + 2) begin
        n_bad++; $display("FAIL held_restart: got %0d/%0d/%0d expected %0d/0/%0d",
                          first_wr, gap_rd, second_rd, N, done_cyc[0] + 2);
      end
    end
    for (int i = 0; i < wr_val.size() && i < 2 * N; i++) begin
      n_cmp++;
      if (wr_val[i] !== ref_val(i)) begin
        n_bad++; $display("FAIL held_word%0d: got %0d expected %0d", i, wr_val[i], ref_val(i));
      end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int unsigned rd_at_rst;
    mode = 0;
    do_start(1'b0);
    for (int i = 0; i < 50 && wr_val.size() < 3; i++) begin
      @(negedge ap_clk); #1;
    end
    ap_rst_n = 1'b0;
    rd_at_rst = rd_cyc.size();
    #1;
    n_cmp++;
    if ({ap_idle, ap_done, rom_ce, output_V_write} !== 4'b1000 ||
        rom_address !== '0 || output_V_din !== '0) begin
      n_bad++; $display("FAIL rstmid_outputs: got %b addr %0d din %0d expected 1000 0 0",
                        {ap_idle, ap_done, rom_ce, output_V_write}, rom_address, output_V_din);
    end
    repeat (3) @(posedge ap_clk);
    #1 ap_rst_n = 1'b1;
    repeat (10) @(negedge ap_clk);
    n_cmp++;
    if (wr_val.size() !== 3 || rd_cyc.size() !== rd_at_rst || done_cyc.size() !== 0) begin
      n_bad++; $display("FAIL rstmid_quiet: got writes %0d reads %0d dones %0d expected 3 %0d 0",
                        wr_val.size(), rd_cyc.size(), done_cyc.size(), rd_at_rst);
    end
    do_start(1'b0);
    wait_done(1, ok);
    n_cmp++;
    if (!ok || wr_val.size() !== N) begin
      n_bad++; $display("FAIL rstmid_rerun: got done %0b writes %0d expected 1 %0d",
                        ok, wr_val.size(), N);
    end
    for (int i = 0; i < wr_val.size() && i < N; i++) begin
      n_cmp++;
      if (wr_val[i] !== ref_val(i)) begin
        n_bad++; $display("FAIL rstmid_word%0d: got %0d expected %0d", i, wr_val[i], ref_val(i));
      end
    end
  endtask

  initial begin
    load_rom_default();
    test_reset();
    test_stream();
    test_backpressure();
    test_alternating();
    test_random();
    test_start_held();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion expected end of tests");
    $fatal(1);
  end

endmodule

// File: doc/bias_stream_ctrl.md
BIAS_STREAM_CTRL -- requirements
Module: bias_stream_ctrl

Interface
REQ-001 SHALL have parameter MEM_SIZE, default 16, number of bias coefficients per pass.
REQ-002 SHALL have parameter DATA_WIDTH, default 16, coefficient width.
REQ-003 SHALL have parameter REPEAT, default 1, number of full passes per start.
REQ-004 SHALL have port ap_clk  in  1  sole clock, rising edge.
REQ-005 SHALL have port ap_rst_n  in  1  asynchronous active-low reset.
REQ-006 SHALL have port ap_start  in  1  start request, sampled in IDLE only.
REQ-007 SHALL have port ap_idle  out  1  high in IDLE.
REQ-008 SHALL have port ap_done  out  1  one-cycle pulse at completion.
REQ-009 SHALL have port rom_address  out  AW  coefficient address; AW = ceil(log2(MEM_SIZE)), minimum 1.
REQ-010 SHALL have port rom_ce  out  1  ROM read enable.
REQ-011 SHALL have port rom_q  in  DATA_WIDTH  ROM data, valid the cycle after rom_ce.
REQ-012 SHALL have port output_V_din  out  DATA_WIDTH  FIFO write data.
REQ-013 SHALL have port output_V_full_n  in  1  FIFO not-full.
REQ-014 SHALL have port output_V_write  out  1  FIFO write strobe.

Function
REQ-015 SHALL implement states IDLE, RUN, DRAIN, DONE.
REQ-016 SHALL move IDLE->RUN when ap_start=1; ap_start in other states SHALL be ignored.
REQ-017 SHALL in RUN issue rom_ce with ascending address 0..MEM_SIZE-1, wrapping to 0 per pass, for REPEAT passes (MEM_SIZE*REPEAT reads total).
REQ-018 SHALL assert rom_ce only when buffer occupancy plus in-flight reads < 2.
REQ-019 SHALL capture rom_q into a 2-entry FIFO buffer the cycle after each rom_ce.
REQ-020 SHALL drive output_V_write = buffer non-empty AND output_V_full_n; output_V_din = buffer head; head pops on write.
REQ-021 SHALL move RUN->DRAIN the cycle after the last read issues; DRAIN->DONE when buffer empty and no read in flight; DONE->IDLE next cycle with ap_done=1 for that cycle only.
REQ-022 SHALL sustain one write per cycle while output_V_full_n stays high.
REQ-023 SHALL, with start sampled at edge k and full_n high, assert rom_ce in cycle k+1 and first output_V_write in cycle k+3.
REQ-024 SHALL never drop, duplicate or reorder coefficients under any full_n pattern, including full_n toggling every cycle.
REQ-025 SHALL treat simultaneous capture and pop as occupancy-neutral.

Reset
REQ-026 SHALL on ap_rst_n=0 immediately enter IDLE, clear counters and buffer; ap_idle=1, ap_done=0, rom_ce=0, output_V_write=0, rom_address=0, output_V_din=0.
REQ-027 SHALL abandon any in-progress pass on reset mid-operation; no write after reset release until a new ap_start.

Configuration
REQ-028 SHALL, with BIAS_STREAM_CTRL_STALL_CNT_EN defined, add port stall_count out 32: counts cycles with buffer non-empty and output_V_full_n=0, cleared on reset and on start acceptance, saturating at all-ones.
REQ-029 SHALL, without BIAS_STREAM_CTRL_STALL_CNT_EN, omit that port and counter with identical remaining behaviour.

Structure
REQ-030 SHALL place state encoding and address-width function in shared package bias_stream_ctrl_pkg.
REQ-031 SHALL implement the 2-entry buffer as sub-module bias_skid_buf.

Verification (MEM_SIZE=4, REPEAT=2, ROM = 10,20,30,40)
REQ-032 SHALL check: start, full_n=1 -> writes 10,20,30,40,10,20,30,40 on consecutive cycles, first write at k+3, ap_done one cycle after last write.
REQ-033 SHALL check: full_n=0 for cycles k+2..k+9 -> at most 2 reads issued, no writes, then full sequence unchanged after release; stall_count=7 or 8 per stall cycles with data pending (when enabled).
REQ-034 SHALL check: full_n alternating 1/0 -> exact 8-value sequence, no loss or duplicate.
REQ-035 SHALL check: ap_start held high through RUN -> single 8-value run, then a second run only after returning to IDLE.
REQ-036 SHALL check: ap_rst_n low after third write -> all outputs at reset values immediately, no writes until next start, new run begins at 10.
